// File: rtl/fifo_pkt.sv
// Single-clock FIFO with first-word-fall-through output, optional packet commit/drop,
// oversize discard, flush, occupancy counts, threshold flags and overflow pulse.
module fifo_pkt #(
    parameter int DATA_WIDTH         = 32,
    parameter int FIFO_DEPTH         = 512,
    parameter int FIFO_SKID          = 0,
    parameter int PACKET_MODE        = 0,
    parameter int ALMOST_FULL_LEVEL  = FIFO_DEPTH - 4,
    parameter int ALMOST_EMPTY_LEVEL = 4,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  flushIn,
    input  logic [DATA_WIDTH-1:0] wrDataIn,
    input  logic                  wrLastIn,
    input  logic                  wrDropIn,
    input  logic                  wrValidIn,
    output logic                  wrReadyOut,
    output logic [DATA_WIDTH-1:0] rdDataOut,
    output logic                  rdLastOut,
    output logic                  rdValidOut,
    input  logic                  rdReadyIn,
    output logic [CW-1:0]         usedCountOut,
    output logic [CW-1:0]         availCountOut,
    output logic                  almostFullOut,
    output logic                  almostEmptyOut,
    output logic                  overflowOut,
    output logic [1:0]            wr_state_dbg
);

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_PKT     = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_t;

    // Handshake: a read beat transfers when rdValidOut & rdReadyIn on a rising edge;
    // a write beat is taken when wrValidIn is high and there is room (or a same-cycle read),
    // wrReadyOut is only advisory above the skid threshold.
    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    wr_state_t           state, state_n;
    logic [PW-1:0]       wr_ptr, rd_ptr, commit_ptr;
    logic [PW-1:0]       wr_ptr_n, rd_ptr_n, commit_n;
    logic [CW-1:0]       used_n, avail_n;
    logic [DATA_WIDTH:0] head_n;
    logic                rd_en, wr_en, full, in_discard, pkt_drop, lost, oversize;

    assign wr_state_dbg = state;

    always_comb begin
        rd_en      = rdReadyIn & rdValidOut;
        full       = (usedCountOut == CW'(FIFO_DEPTH));
        in_discard = (state == WR_DISCARD);
        wr_en      = wrValidIn & (~full | rd_en) & ~in_discard;
        pkt_drop   = (PACKET_MODE != 0) && (state == WR_PKT) && wrDropIn;
        lost       = wrValidIn & full & ~rd_en & ~in_discard & ~pkt_drop;
        // A packet that cannot grow any further can never commit, so it is abandoned whole.
        oversize   = (PACKET_MODE != 0) && (state == WR_PKT) && lost;

        rd_ptr_n = rd_ptr + PW'(rd_en);
        wr_ptr_n = wr_ptr + PW'(wr_en);
        commit_n = commit_ptr;
        state_n  = state;
        used_n   = usedCountOut + CW'(wr_en) - CW'(rd_en);
        avail_n  = availCountOut - CW'(rd_en);

        if (PACKET_MODE == 0) begin
            avail_n  = used_n;
            commit_n = wr_ptr_n;
        end else if (pkt_drop || oversize) begin
            wr_ptr_n = commit_ptr;
            used_n   = avail_n;
            state_n  = oversize ? WR_DISCARD : WR_IDLE;
        end else if (in_discard) begin
            if (wrValidIn && wrLastIn) state_n = WR_IDLE;
        end else if (wr_en) begin
            if (wrLastIn) begin
                commit_n = wr_ptr_n;
                avail_n  = used_n;
                state_n  = WR_IDLE;
            end else begin
                state_n = WR_PKT;
            end
        end

        // The next head slot is only being written this edge when the FIFO drains to empty.
        head_n = (wr_en && (wr_ptr == rd_ptr_n)) ? {wrLastIn, wrDataIn} : mem[rd_ptr_n];
    end

    always_ff @(posedge clkIn) begin
        if (wr_en && !rstIn && !flushIn) mem[wr_ptr] <= {wrLastIn, wrDataIn};
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state          <= WR_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            commit_ptr     <= '0;
            usedCountOut   <= '0;
            availCountOut  <= '0;
            wrReadyOut     <= 1'b0;
            rdValidOut     <= 1'b0;
            rdLastOut      <= 1'b0;
            rdDataOut      <= '0;
            almostFullOut  <= 1'b0;
            almostEmptyOut <= 1'b1;
            overflowOut    <= 1'b0;
        end else if (flushIn) begin
            state          <= WR_IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            commit_ptr     <= '0;
            usedCountOut   <= '0;
            availCountOut  <= '0;
            wrReadyOut     <= 1'b1;
            rdValidOut     <= 1'b0;
            almostFullOut  <= (ALMOST_FULL_LEVEL <= 0);
            almostEmptyOut <= (ALMOST_EMPTY_LEVEL >= 0);
            overflowOut    <= 1'b0;
        end else begin
            state          <= state_n;
            wr_ptr         <= wr_ptr_n;
            rd_ptr         <= rd_ptr_n;
            commit_ptr     <= commit_n;
            usedCountOut   <= used_n;
            availCountOut  <= avail_n;
            wrReadyOut     <= (state_n == WR_DISCARD) || (used_n < CW'(FIFO_DEPTH - FIFO_SKID));
            rdValidOut     <= (avail_n != '0);
            rdDataOut      <= head_n[DATA_WIDTH-1:0];
            rdLastOut      <= head_n[DATA_WIDTH];
            almostFullOut  <= (used_n >= CW'(ALMOST_FULL_LEVEL));
            almostEmptyOut <= (avail_n <= CW'(ALMOST_EMPTY_LEVEL));
            overflowOut    <= lost;
        end
    end

endmodule

// File: tb/tb_fifo_pkt.sv
// Bench for fifo_pkt: one streaming-mode and one packet-mode instance (depth 8, skid 2),
// each checked every cycle against a queue-level model, plus directed literal checks.
module tb_fifo_pkt;

    localparam int DW = 8;
    localparam int D  = 8;
    localparam int SK = 2;
    localparam int AF = D - 4;
    localparam int AE = 4;

    logic clk;
    logic rst;
    bit   chk_on;
    int   tests;
    int   fails;

    // streaming-mode instance signals
    logic          fl0, wl0, dr0, wv0, rr0;
    logic [DW-1:0] wd0, data0;
    logic          ready0, last0, valid0, af0, ae0, ovf0;
    logic [3:0]    used0, avail0;
    logic [1:0]    st_dbg0;

    // packet-mode instance signals
    logic          fl1, wl1, dr1, wv1, rr1;
    logic [DW-1:0] wd1, data1;
    logic          ready1, last1, valid1, af1, ae1, ovf1;
    logic [3:0]    used1, avail1;
    logic [1:0]    st_dbg1;

    fifo_pkt #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FIFO_SKID(SK), .PACKET_MODE(0)) u_m0 (
        .clkIn(clk), .rstIn(rst), .flushIn(fl0), .wrDataIn(wd0), .wrLastIn(wl0),
        .wrDropIn(dr0), .wrValidIn(wv0), .wrReadyOut(ready0), .rdDataOut(data0),
        .rdLastOut(last0), .rdValidOut(valid0), .rdReadyIn(rr0), .usedCountOut(used0),
        .availCountOut(avail0), .almostFullOut(af0), .almostEmptyOut(ae0),
        .overflowOut(ovf0), .wr_state_dbg(st_dbg0)
    );

    fifo_pkt #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FIFO_SKID(SK), .PACKET_MODE(1)) u_m1 (
        .clkIn(clk), .rstIn(rst), .flushIn(fl1), .wrDataIn(wd1), .wrLastIn(wl1),
        .wrDropIn(dr1), .wrValidIn(wv1), .wrReadyOut(ready1), .rdDataOut(data1),
        .rdLastOut(last1), .rdValidOut(valid1), .rdReadyIn(rr1), .usedCountOut(used1),
        .availCountOut(avail1), .almostFullOut(af1), .almostEmptyOut(ae1),
        .overflowOut(ovf1), .wr_state_dbg(st_dbg1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference models ----------------
    // Streaming mode: every accepted word is immediately readable.
    logic [DW:0] exp_q0[$];
    bit          e0_ready, e0_ovf, m0_rd, m0_full;

    always @(posedge clk) begin
        if (rst) begin
            exp_q0.delete();
            e0_ready = 1'b0;
            e0_ovf   = 1'b0;
        end else if (fl0) begin
            exp_q0.delete();
            e0_ready = 1'b1;
            e0_ovf   = 1'b0;
        end else begin
            m0_rd   = rr0 && (exp_q0.size() != 0);
            m0_full = (exp_q0.size() == D);
            e0_ovf  = 1'b0;
            if (m0_rd) void'(exp_q0.pop_front());
            if (wv0) begin
                if (!m0_full || m0_rd) exp_q0.push_back({wl0, wd0});
                else e0_ovf = 1'b1;
            end
            e0_ready = (exp_q0.size() < D - SK);
        end
    end

    // Packet mode: committed words (readable) and the open packet kept separately.
    logic [DW:0] exp_q1[$];
    logic [DW:0] pend_q1[$];
    int          st1;  // 0 idle, 1 inside packet, 2 discarding
    bit          e1_ready, e1_ovf, m1_rd, m1_full;

    always @(posedge clk) begin
        if (rst || fl1) begin
            exp_q1.delete();
            pend_q1.delete();
            st1      = 0;
            e1_ready = !rst;
            e1_ovf   = 1'b0;
        end else begin
            m1_rd   = rr1 && (exp_q1.size() != 0);
            m1_full = (exp_q1.size() + pend_q1.size() == D);
            e1_ovf  = 1'b0;
            if (m1_rd) void'(exp_q1.pop_front());
            if (st1 == 1 && dr1) begin
                pend_q1.delete();
                st1 = 0;
            end else if (st1 == 1 && wv1 && m1_full && !m1_rd) begin
                pend_q1.delete();
                e1_ovf = 1'b1;
                st1    = 2;
            end else if (st1 == 2) begin
                if (wv1 && wl1) st1 = 0;
            end else if (wv1) begin
                if (!m1_full || m1_rd) begin
                    pend_q1.push_back({wl1, wd1});
                    if (wl1) begin
                        foreach (pend_q1[k]) exp_q1.push_back(pend_q1[k]);
                        pend_q1.delete();
                        st1 = 0;
                    end else begin
                        st1 = 1;
                    end
                end else begin
                    e1_ovf = 1'b1;
                end
            end
            e1_ready = (st1 == 2) || (exp_q1.size() + pend_q1.size() < D - SK);
        end
    end

    // ---------------- per-cycle compare ----------------
    int n0, c1, u1;
    always @(negedge clk) begin
        if (chk_on) begin
            n0 = exp_q0.size();
            check("m0_ready", 32'(ready0), 32'(e0_ready));
            check("m0_valid", 32'(valid0), 32'(n0 != 0));
            check("m0_used",  32'(used0),  32'(n0));
            check("m0_avail", 32'(avail0), 32'(n0));
            check("m0_afull", 32'(af0),    32'(n0 >= AF));
            check("m0_aempty",32'(ae0),    32'(n0 <= AE));
            check("m0_ovf",   32'(ovf0),   32'(e0_ovf));
            if (n0 != 0) begin
                check("m0_data", 32'(data0), 32'(exp_q0[0][DW-1:0]));
                check("m0_last", 32'(last0), 32'(exp_q0[0][DW]));
            end
            c1 = exp_q1.size();
            u1 = c1 + pend_q1.size();
            check("m1_ready", 32'(ready1), 32'(e1_ready));
            check("m1_valid", 32'(valid1), 32'(c1 != 0));
            check("m1_used",  32'(used1),  32'(u1));
            check("m1_avail", 32'(avail1), 32'(c1));
            check("m1_afull", 32'(af1),    32'(u1 >= AF));
            check("m1_aempty",32'(ae1),    32'(c1 <= AE));
            check("m1_ovf",   32'(ovf1),   32'(e1_ovf));
            if (c1 != 0) begin
                check("m1_data", 32'(data1), 32'(exp_q1[0][DW-1:0]));
                check("m1_last", 32'(last1), 32'(exp_q1[0][DW]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        fl0 = 0; wl0 = 0; dr0 = 0; wv0 = 0; rr0 = 0; wd0 = '0;
        fl1 = 0; wl1 = 0; dr1 = 0; wv1 = 0; rr1 = 0; wd1 = '0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic put1(input logic [DW-1:0] d, input logic l);
        wv1 = 1; wd1 = d; wl1 = l;
        step();
        wv1 = 0; wl1 = 0;
    endtask

    // ---------------- stimulus ----------------
    bit saw_ovf;

    initial begin
        tests = 0;
        fails = 0;
        chk_on = 0;
        idle_inputs();
        rst = 1;
        step();
        chk_on = 1;
        step();
        rst = 0;
        step();

        // Fill the streaming FIFO past full without reading.
        for (int i = 0; i <= 8; i++) begin
            wv0 = 1; wd0 = 8'(i);
            step();
            if (i == 4) check("lit_ready_at5", 32'(ready0), 32'd1);
            if (i == 5) check("lit_ready_at6", 32'(ready0), 32'd0);
            if (i == 7) check("lit_used_full", 32'(used0), 32'd8);
            if (i == 8) check("lit_ovf_pulse", 32'(ovf0), 32'd1);
        end
        wv0 = 0;
        step();
        check("lit_ovf_clear", 32'(ovf0), 32'd0);
        rr0 = 1;
        for (int i = 0; i < 8; i++) begin
            check("lit_read_order", 32'(data0), 32'(i));
            step();
        end
        rr0 = 0;
        check("lit_drained", 32'(valid0), 32'd0);

        // Fall-through latency and steady read+write.
        wv0 = 1; wd0 = 8'hA5;
        step();
        wv0 = 0;
        check("lit_fwft_valid", 32'(valid0), 32'd1);
        check("lit_fwft_data", 32'(data0), 32'hA5);
        rr0 = 1; wv0 = 1;
        for (int i = 0; i < 20; i++) begin
            wd0 = 8'(i + 1); wl0 = (i % 5 == 4);
            step();
            check("lit_steady_used", 32'(used0), 32'd1);
        end
        wv0 = 0; wl0 = 0;
        step();
        rr0 = 0;

        // Packet commit on last beat.
        put1(8'd1, 0);
        check("lit_pkt_hidden1", 32'(valid1), 32'd0);
        put1(8'd2, 0);
        check("lit_pkt_hidden2", 32'(valid1), 32'd0);
        put1(8'd3, 1);
        check("lit_pkt_commit", 32'(avail1), 32'd3);
        rr1 = 1;
        for (int i = 1; i <= 3; i++) begin
            check("lit_pkt_data", 32'(data1), 32'(i));
            check("lit_pkt_last", 32'(last1), 32'(i == 3));
            step();
        end
        rr1 = 0;

        // Drop rewinds the open packet.
        put1(8'h10, 0);
        put1(8'h11, 0);
        dr1 = 1;
        step();
        dr1 = 0;
        check("lit_drop_used", 32'(used1), 32'd0);
        check("lit_drop_valid", 32'(valid1), 32'd0);
        put1(8'h20, 1);
        check("lit_after_drop_data", 32'(data1), 32'h20);
        check("lit_after_drop_avail", 32'(avail1), 32'd1);
        rr1 = 1;
        step();
        rr1 = 0;

        // Oversize packet behind a committed 2-word packet.
        put1(8'h30, 0);
        put1(8'h31, 1);
        saw_ovf = 0;
        wv1 = 1;
        for (int i = 0; i < 10; i++) begin
            wd1 = 8'(8'h40 + i); wl1 = (i == 9);
            step();
            if (ovf1) saw_ovf = 1;
        end
        wv1 = 0; wl1 = 0;
        check("lit_oversize_ovf", 32'(saw_ovf), 32'd1);
        check("lit_oversize_avail", 32'(avail1), 32'd2);
        check("lit_oversize_used", 32'(used1), 32'd2);
        rr1 = 1;
        check("lit_keep0", 32'(data1), 32'h30);
        step();
        check("lit_keep1", 32'(data1), 32'h31);
        check("lit_keep1_last", 32'(last1), 32'd1);
        step();
        rr1 = 0;

        // Flush with pointers at 6, during a read plus a write.
        put1(8'h60, 1);
        rr1 = 1; wv1 = 1; wd1 = 8'h61; wl1 = 1; fl1 = 1;
        step();
        rr1 = 0; wv1 = 0; wl1 = 0; fl1 = 0;
        check("lit_flush_used", 32'(used1), 32'd0);
        check("lit_flush_avail", 32'(avail1), 32'd0);
        check("lit_flush_valid", 32'(valid1), 32'd0);
        check("lit_flush_ready", 32'(ready1), 32'd1);
        for (int i = 0; i < 4; i++) put1(8'(i), (i == 3));
        rr1 = 1;
        for (int i = 0; i < 4; i++) begin
            check("lit_post_flush", 32'(data1), 32'(i));
            step();
        end
        rr1 = 0;

        // Randomised traffic on both instances, alternating write-heavy and read-heavy.
        for (int c = 0; c < 800; c++) begin
            wv0 = $urandom_range(0, 3) != 0;
            wd0 = 8'($urandom_range(0, 255));
            wl0 = $urandom_range(0, 1) != 0;
            dr0 = $urandom_range(0, 7) == 0;
            rr0 = (c % 160 < 80) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl0 = $urandom_range(0, 99) == 0;
            wv1 = $urandom_range(0, 3) != 0;
            wd1 = 8'($urandom_range(0, 255));
            wl1 = $urandom_range(0, 3) == 0;
            dr1 = (st1 == 1) && ($urandom_range(0, 15) == 0);
            rr1 = (c % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl1 = $urandom_range(0, 99) == 0;
            step();
        end
        idle_inputs();

        // Reset in the middle of traffic.
        wv0 = 1; wd0 = 8'h77; wv1 = 1; wd1 = 8'h78;
        step();
        step();
        rst = 1;
        step();
        idle_inputs();
        step();
        rst = 0;
        step();
        check("lit_reset_used0", 32'(used0), 32'd0);
        check("lit_reset_used1", 32'(used1), 32'd0);
        put1(8'h99, 1);
        check("lit_reset_reuse", 32'(data1), 32'h99);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
